param_incr_pipeline: RTL and testbench

- Parametrised successor to the fixed two-stage add-one pipeline.
- Registers an input word, adds a compile-time constant with either wrap or saturate semantics, and delays the result through a configurable number of stages.
- Adds valid/ready backpressure with per-stage stall, an overflow sideband and an occupancy count.
- Sits between a producer and consumer that both use valid/ready streaming.

---
 rtl/param_incr_pkg.sv | 41 ++++
 rtl/pipe_stage.sv | 46 ++++
 rtl/param_incr_pipeline.sv | 114 +++++++++++
 tb/tb_param_incr_pipeline.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/param_incr_pkg.sv
// rtl/param_incr_pkg.sv - shared helpers for the parametrised increment pipeline
package param_incr_pkg;

    localparam int MAX_WIDTH = 64;

    function automatic int occ_width(input int stages);
        return $clog2(stages + 1);
    endfunction

    function automatic bit stages_ok(input int stages);
        return stages >= 2;
    endfunction

    function automatic bit width_ok(input int width);
        return (width >= 1) && (width <= MAX_WIDTH);
    endfunction

    function automatic bit increment_ok(input longint unsigned inc, input int width);
        if (width >= MAX_WIDTH) return 1'b1;
        return inc < (64'd1 << width);
    endfunction

    // Result is {ovf, sum}; sum bits above width are zero.
    function automatic logic [MAX_WIDTH:0] sat_add(
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] inc,
        input int                   width,
        input logic                 sat
    );
        logic [MAX_WIDTH:0]   full;
        logic [MAX_WIDTH:0]   mask;
        logic [MAX_WIDTH-1:0] res;
        logic                 ovf;
        full = {1'b0, a} + {1'b0, inc};
        mask = ((MAX_WIDTH+1)'(1) << width) - (MAX_WIDTH+1)'(1);
        ovf  = |(full & ~mask);
        res  = (sat && ovf) ? mask[MAX_WIDTH-1:0] : (full[MAX_WIDTH-1:0] & mask[MAX_WIDTH-1:0]);
        return {ovf, res};
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one valid/data/overflow register stage with load enable
module pipe_stage
    import param_incr_pkg::*;
#(
    parameter int WIDTH           = 32,
    parameter bit RESET_DATA_PATH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_ovf,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             ovf
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
        end else if (load_en) begin
            valid <= in_valid;
        end
    end

    if (RESET_DATA_PATH) begin : g_rst_data
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                data <= '0;
                ovf  <= 1'b0;
            end else if (load_en) begin
                data <= in_data;
                ovf  <= in_ovf;
            end
        end
    end else begin : g_norst_data
        always_ff @(posedge clk) begin
            if (load_en) begin
                data <= in_data;
                ovf  <= in_ovf;
            end
        end
    end

endmodule

// File: rtl/param_incr_pipeline.sv
// rtl/param_incr_pipeline.sv - valid/ready pipeline adding a constant with wrap or saturate
module param_incr_pipeline
    import param_incr_pkg::*;
#(
    parameter int              WIDTH           = 32,
    parameter int              STAGES          = 2,
    parameter longint unsigned INCREMENT       = 1,
    parameter bit              SATURATE        = 1'b0,
    parameter bit              RESET_DATA_PATH = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            input_valid,
    output logic                            input_ready,
    input  logic [WIDTH-1:0]                x,
    output logic                            output_valid,
    input  logic                            output_ready,
    output logic [WIDTH-1:0]                out,
    output logic                            out_overflow,
    output logic [occ_width(STAGES)-1:0]    occupancy
);

    localparam int OCC_W = occ_width(STAGES);

    if (!stages_ok(STAGES)) begin : g_bad_stages
        $error("param_incr_pipeline: STAGES must be at least 2");
    end
    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("param_incr_pipeline: WIDTH out of range");
    end
    if (!increment_ok(INCREMENT, WIDTH)) begin : g_bad_inc
        $error("param_incr_pipeline: INCREMENT must fit in WIDTH bits");
    end

    logic [STAGES-1:0]  valid;
    logic [STAGES-1:0]  ready;
    logic [STAGES-1:0]  next_valid;
    logic [WIDTH-1:0]   data [STAGES];
    logic               ovf  [STAGES];
    logic [MAX_WIDTH:0] add_res;
    logic [OCC_W-1:0]   occ_next;

    assign add_res = sat_add(MAX_WIDTH'(data[0]), MAX_WIDTH'(INCREMENT), WIDTH, SATURATE);

    // A stage may load when it is empty or everything ahead of it is draining.
    always_comb begin
        ready = '0;
        ready[STAGES-1] = output_ready | ~valid[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) begin
            ready[k] = ready[k+1] | ~valid[k];
        end
    end

    always_comb begin
        next_valid    = valid;
        next_valid[0] = ready[0] ? input_valid : valid[0];
        for (int k = 1; k < STAGES; k++) begin
            next_valid[k] = ready[k] ? valid[k-1] : valid[k];
        end
        occ_next = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ_next = occ_next + OCC_W'(next_valid[k]);
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             in_v;
        logic [WIDTH-1:0] in_d;
        logic             in_o;

        if (k == 0) begin : g_capture
            assign in_v = input_valid;
            assign in_d = x;
            assign in_o = 1'b0;
        end else if (k == 1) begin : g_add
            assign in_v = valid[0];
            assign in_d = WIDTH'(add_res[MAX_WIDTH-1:0]);
            assign in_o = add_res[MAX_WIDTH];
        end else begin : g_copy
            assign in_v = valid[k-1];
            assign in_d = data[k-1];
            assign in_o = ovf[k-1];
        end

        pipe_stage #(
            .WIDTH           (WIDTH),
            .RESET_DATA_PATH (RESET_DATA_PATH)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .load_en  (ready[k]),
            .in_valid (in_v),
            .in_data  (in_d),
            .in_ovf   (in_o),
            .valid    (valid[k]),
            .data     (data[k]),
            .ovf      (ovf[k])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_next;
        end
    end

    assign input_ready  = ready[0] & rst;
    assign output_valid = valid[STAGES-1];
    assign out          = data[STAGES-1];
    assign out_overflow = ovf[STAGES-1];

endmodule

// File: tb/tb_param_incr_pipeline.sv
// tb/tb_param_incr_pipeline.sv - self-checking bench for param_incr_pipeline
module tb_param_incr_pipeline;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        input_valid;
    logic        output_ready;
    logic [31:0] x;

    logic        ir0, ov0, ovf0;
    logic [31:0] out0;
    logic [2:0]  occ0;
    logic        ir1, ov1, ovf1;
    logic [7:0]  out1;
    logic [1:0]  occ1;

    int n_checks = 0;
    int n_fail   = 0;

    longint unsigned mx [2][16];
    int              ma [2][16];
    int              hd [2];
    int              tl [2];
    int              ldep [2];
    int              cyc;
    bit              exp_v [2];
    bit              exp_ir [2];

    always #5 clk = ~clk;

    param_incr_pipeline #(
        .WIDTH(32), .STAGES(4), .INCREMENT(1), .SATURATE(0), .RESET_DATA_PATH(1)
    ) dut0 (
        .clk(clk), .rst(rst_n), .input_valid(input_valid), .input_ready(ir0), .x(x),
        .output_valid(ov0), .output_ready(output_ready), .out(out0),
        .out_overflow(ovf0), .occupancy(occ0)
    );

    param_incr_pipeline #(
        .WIDTH(8), .STAGES(2), .INCREMENT(1), .SATURATE(1), .RESET_DATA_PATH(0)
    ) dut1 (
        .clk(clk), .rst(rst_n), .input_valid(input_valid), .input_ready(ir1), .x(x[7:0]),
        .output_valid(ov1), .output_ready(output_ready), .out(out1),
        .out_overflow(ovf1), .occupancy(occ1)
    );

    function automatic int stg(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    function automatic longint unsigned msk(input int i);
        return (i == 0) ? 64'hFFFF_FFFF : 64'hFF;
    endfunction

    function automatic longint unsigned ref_sum(input int i, input longint unsigned xv);
        longint unsigned s;
        s = xv + 1;
        if (s > msk(i)) return (i == 1) ? msk(i) : (s & msk(i));
        return s;
    endfunction

    function automatic bit ref_ovf(input int i, input longint unsigned xv);
        return (xv + 1) > msk(i);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            hd[i]   = 0;
            tl[i]   = 0;
            ldep[i] = -1000;
        end
    endtask

    // Item i reaches the output at max(accept + STAGES - 1, departure of item i-1).
    task automatic eval_and_check();
        for (int i = 0; i < 2; i++) begin
            int          n;
            int          arr;
            logic        gv, gir, govf;
            logic [63:0] gout, gocc;
            n   = tl[i] - hd[i];
            arr = (n > 0) ? ma[i][hd[i] % 16] + stg(i) - 1 : 0;
            if (ldep[i] > arr) arr = ldep[i];
            exp_v[i]  = (rst_n === 1'b1) && (n > 0) && (arr <= cyc);
            exp_ir[i] = (rst_n === 1'b1) && ((n < stg(i)) || output_ready);
            if (i == 0) begin
                gv = ov0; gir = ir0; govf = ovf0; gout = 64'(out0); gocc = 64'(occ0);
            end else begin
                gv = ov1; gir = ir1; govf = ovf1; gout = 64'(out1); gocc = 64'(occ1);
            end
            check_eq($sformatf("output_valid[%0d]", i), 64'(gv), 64'(exp_v[i]));
            check_eq($sformatf("input_ready[%0d]", i), 64'(gir), 64'(exp_ir[i]));
            check_eq($sformatf("occupancy[%0d]", i), gocc, 64'(n));
            if (exp_v[i]) begin
                check_eq($sformatf("out[%0d]", i), gout, ref_sum(i, mx[i][hd[i] % 16]));
                check_eq($sformatf("out_overflow[%0d]", i), 64'(govf),
                         64'(ref_ovf(i, mx[i][hd[i] % 16])));
            end
        end
    endtask

    task automatic step(input bit iv, input logic [31:0] xv, input bit ordy);
        @(negedge clk);
        input_valid  = iv;
        x            = xv;
        output_ready = ordy;
        #1;
        eval_and_check();
        @(posedge clk);
        cyc++;
        if (rst_n === 1'b1) begin
            for (int i = 0; i < 2; i++) begin
                if (exp_v[i] && ordy) begin
                    hd[i]++;
                    ldep[i] = cyc;
                end
                if (iv && exp_ir[i]) begin
                    mx[i][tl[i] % 16] = 64'(xv) & msk(i);
                    ma[i][tl[i] % 16] = cyc;
                    tl[i]++;
                end
            end
        end
    endtask

    task automatic reset_checks();
        check_eq("rst_output_valid[0]", 64'(ov0), 64'd0);
        check_eq("rst_output_valid[1]", 64'(ov1), 64'd0);
        check_eq("rst_occupancy[0]", 64'(occ0), 64'd0);
        check_eq("rst_occupancy[1]", 64'(occ1), 64'd0);
        check_eq("rst_input_ready[0]", 64'(ir0), 64'd0);
        check_eq("rst_input_ready[1]", 64'(ir1), 64'd0);
        check_eq("rst_out[0]", 64'(out0), 64'd0);
        check_eq("rst_out_overflow[0]", 64'(ovf0), 64'd0);
    endtask

    task automatic pulse_reset();
        #3;
        input_valid = 1'b0;
        rst_n       = 1'b0;
        #1;
        reset_checks();
        model_clear();
        @(posedge clk); cyc++;
        @(posedge clk); cyc++;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] xv;
        int          r;
        input_valid  = 1'b0;
        output_ready = 1'b0;
        x            = '0;
        cyc          = 0;
        model_clear();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 reset_checks();
        @(posedge clk); cyc++;
        @(posedge clk); cyc++;
        #1 rst_n = 1'b1;

        // streaming and overflow boundary
        step(1'b1, 32'd0, 1'b1);
        step(1'b1, 32'd1, 1'b1);
        step(1'b1, 32'd5, 1'b1);
        step(1'b1, 32'hFFFF_FFFE, 1'b1);
        step(1'b1, 32'hFFFF_FFFF, 1'b1);
        for (int j = 0; j < 6; j++) step(1'b0, 32'd0, 1'b1);

        // backpressure on a full pipeline
        for (int j = 0; j < 6; j++) step(1'b1, 32'(10 + j), 1'b0);
        #1;
        check_eq("bp_full_occupancy", 64'(occ0), 64'd4);
        check_eq("bp_full_input_ready", 64'(ir0), 64'd0);
        for (int j = 0; j < 8; j++) step(1'b0, 32'd0, 1'b1);

        // sparse input collapses bubbles while stalled
        for (int j = 0; j < 6; j++) begin
            step(1'b1, 32'(100 + j), 1'b0);
            step(1'b0, 32'd0, 1'b0);
            step(1'b0, 32'd0, 1'b0);
        end
        for (int j = 0; j < 8; j++) step(1'b0, 32'd0, 1'b1);

        // reset with items in flight, then a first item after release
        for (int j = 0; j < 3; j++) step(1'b1, 32'(200 + j), 1'b0);
        pulse_reset();
        step(1'b1, 32'd7, 1'b1);
        for (int j = 0; j < 6; j++) step(1'b0, 32'd0, 1'b1);

        for (int j = 0; j < 3000; j++) begin
            if (j == 1500) pulse_reset();
            r  = int'($urandom_range(0, 7));
            xv = (r == 0) ? 32'hFFFF_FFFF : (r == 1) ? 32'h0000_00FF : $urandom();
            step($urandom_range(0, 3) != 0, xv, $urandom_range(0, 2) != 0);
        end
        for (int j = 0; j < 8; j++) step(1'b0, 32'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
